// File: rtl/player_path_animator_pkg.sv
// Board geometry, animation states and shared helpers
// for the dice race player path animator.
package player_path_animator_pkg;

    localparam int NUM_TILES  = 32;
    localparam int COLS       = 8;
    localparam int TILE_W     = 32;
    localparam int ORIGIN_X   = 64;
    localparam int ORIGIN_Y   = 96;
    localparam int SPEED      = 2;
    localparam int SPRITE_OFS = 8;

    localparam logic [5:0] LAST_TILE = 6'(NUM_TILES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MOVE,
        GOAL
    } anim_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } tile_pos_t;

    localparam tile_pos_t START_POS = '{
        x: 10'(ORIGIN_X + SPRITE_OFS),
        y: 10'(ORIGIN_Y + SPRITE_OFS)
    };

    // Hop height: peaks at mid-tile, zero at both endpoints.
    function automatic logic [9:0] hop_of(input logic [5:0] d);
        logic [5:0] a;
        logic [5:0] b;
        a = d;
        b = 6'(TILE_W) - d;
        return 10'(((a < b) ? a : b) >> 2);
    endfunction

endpackage

// File: rtl/player_path_animator_if.sv
// Control and sprite-position bundle between the game FSM,
// the animator and the sprite stage.
interface player_path_animator_if;

    logic       frame_tick;
    logic       restart;
    logic       move_start;
    logic [2:0] move_steps;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [5:0] tile_idx;
    logic       busy;
    logic       done;
    logic       at_goal;

    modport master (
        output frame_tick, restart, move_start, move_steps,
        input  player_x, player_y, tile_idx, busy, done, at_goal
    );

    modport slave (
        input  frame_tick, restart, move_start, move_steps,
        output player_x, player_y, tile_idx, busy, done, at_goal
    );

endinterface

// File: rtl/player_path_animator_tile_pos_lut.sv
// Serpentine tile index to sprite top-left pixel position.
// Even rows run left to right, odd rows right to left.
module tile_pos_lut
    import player_path_animator_pkg::*;
(
    input  logic [5:0] idx_i,
    output tile_pos_t  pos_o
);

    logic [5:0] row;
    logic [5:0] c;
    logic [5:0] col;

    // Split index into row/column and fold odd rows.
    always_comb begin
        row     = idx_i / 6'(COLS);
        c       = idx_i % 6'(COLS);
        col     = row[0] ? (6'(COLS - 1) - c) : c;
        pos_o.x = 10'(ORIGIN_X) + 10'(col) * 10'(TILE_W)
                + 10'(SPRITE_OFS);
        pos_o.y = 10'(ORIGIN_Y) + 10'(row) * 10'(TILE_W)
                + 10'(SPRITE_OFS);
    end

endmodule

// File: rtl/player_path_animator.sv
// Per-player track walker: steps N tiles per dice roll, SPEED px per frame.
// Optional build macro PLAYER_HOP_EN adds a hop arc to player_y while moving.
module player_path_animator
    import player_path_animator_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    player_path_animator_if.slave bus
);

    anim_state_t state_q;
    logic [5:0]  tile_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [9:0]  yo_q;
    tile_pos_t   tgt_q;
    logic [2:0]  rem_q;
    logic [5:0]  dist_q;
    logic        busy_q;
    logic        done_q;
    logic        goal_q;

    logic [5:0]  nxt_idx;
    tile_pos_t   nxt_pos;
    logic [9:0]  x_d;
    logic [9:0]  y_d;
    logic [5:0]  dist_d;
    logic [5:0]  tile_d;
    logic [2:0]  rem_d;
    logic [9:0]  hop_d;
    logic        arrive;
    logic        steps_ok;

    assign nxt_idx = tile_q + 6'd1;

    tile_pos_lut u_lut (
        .idx_i (nxt_idx),
        .pos_o (nxt_pos)
    );

    // One SPEED step toward the target; x first, then y (row change).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q < tgt_q.x) begin
            x_d = x_q + 10'(SPEED);
        end else if (x_q > tgt_q.x) begin
            x_d = x_q - 10'(SPEED);
        end else if (y_q < tgt_q.y) begin
            y_d = y_q + 10'(SPEED);
        end
        dist_d   = dist_q + 6'(SPEED);
        arrive   = (x_d == tgt_q.x) && (y_d == tgt_q.y);
        tile_d   = tile_q + 6'd1;
        rem_d    = rem_q - 3'd1;
        steps_ok = (bus.move_steps != 3'd0)
                && (bus.move_steps != 3'd7);
`ifdef PLAYER_HOP_EN
        hop_d = hop_of(dist_d);
`else
        hop_d = '0;
`endif
    end

    // Animation FSM with registered position and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tile_q  <= '0;
            x_q     <= START_POS.x;
            y_q     <= START_POS.y;
            yo_q    <= START_POS.y;
            tgt_q   <= START_POS;
            rem_q   <= '0;
            dist_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            goal_q  <= 1'b0;
        end else if (bus.restart) begin
            state_q <= IDLE;
            tile_q  <= '0;
            x_q     <= START_POS.x;
            y_q     <= START_POS.y;
            yo_q    <= START_POS.y;
            tgt_q   <= START_POS;
            rem_q   <= '0;
            dist_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            goal_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.move_start && steps_ok) begin
                        rem_q   <= bus.move_steps;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (tile_q == LAST_TILE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        goal_q  <= 1'b1;
                        state_q <= GOAL;
                    end else begin
                        tgt_q   <= nxt_pos;
                        dist_q  <= '0;
                        state_q <= MOVE;
                    end
                end
                MOVE: begin
                    if (bus.frame_tick) begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        dist_q <= dist_d;
                        yo_q   <= arrive ? y_d : (y_d - hop_d);
                        if (arrive) begin
                            tile_q <= tile_d;
                            rem_q  <= rem_d;
                            dist_q <= '0;
                            if (tile_d == LAST_TILE) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                goal_q  <= 1'b1;
                                state_q <= GOAL;
                            end else if (rem_d == 3'd0) begin
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                GOAL: begin
                    goal_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.player_x = x_q;
    assign bus.player_y = yo_q;
    assign bus.tile_idx = tile_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.at_goal  = goal_q;

endmodule
